// File: rtl/id_issue_ctrl.sv
// ID-stage issue controller: IMM_SEL decode, load-use / M-unit hazard handling, IF/ID and ID/EX slots.
// Latency: one cycle ID->EX; load-use costs one bubble; EX_BUSY holds IF, ID and ID/EX while asserted.
module id_issue_ctrl #(
    parameter int   CNT_W       = 16,
    parameter logic LOAD_USE_EN = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IF_VALID,
    input  logic [31:0]      IF_INST,
    input  logic             EX_BUSY,
    input  logic             FLUSH,
    output logic [3:0]       IMM_SEL,
    output logic [31:0]      ID_INST,
    output logic             ID_VALID,
    output logic             STALL_IF,
    output logic             EXE_VALID,
    output logic [3:0]       EXE_IMM_SEL,
    output logic [4:0]       EXE_RD,
    output logic             EXE_MEM_READ,
    output logic [CNT_W-1:0] STALL_CNT
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_BUBBLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [1:0]       r_state;
    logic [31:0]      r_id_inst;
    logic             r_id_valid;
    logic             r_exe_valid;
    logic [3:0]       r_exe_imm_sel;
    logic [4:0]       r_exe_rd;
    logic             r_exe_mem_read;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [6:0]       w_opcode;
    logic [2:0]       w_funct3;
    logic [3:0]       w_imm_sel;
    logic             w_rs1_used;
    logic             w_rs2_used;
    logic             w_load_use;
    logic             w_cnt_inc;

    assign w_opcode = r_id_inst[6:0];
    assign w_funct3 = r_id_inst[14:12];

    always_comb begin
        w_imm_sel = 4'b0111;
        case (w_opcode)
            OP_LUI, OP_AUIPC: w_imm_sel = 4'b0000;
            OP_JAL:           w_imm_sel = 4'b0001;
            OP_LOAD, OP_JALR: w_imm_sel = 4'b0010;
            OP_IMM:           w_imm_sel = (w_funct3 == 3'b001 || w_funct3 == 3'b101) ? 4'b0101 : 4'b0010;
            OP_BRANCH:        w_imm_sel = 4'b0011;
            OP_STORE:         w_imm_sel = 4'b0100;
            default:          w_imm_sel = 4'b0111;
        endcase
    end

    assign w_rs1_used = !(w_opcode == OP_LUI || w_opcode == OP_AUIPC || w_opcode == OP_JAL);
    assign w_rs2_used = (w_opcode == OP_REG) || (w_opcode == OP_STORE) || (w_opcode == OP_BRANCH);

    // The BUBBLE term is redundant with EXE_VALID=0 but makes the single-bubble guarantee explicit.
    assign w_load_use = LOAD_USE_EN && r_id_valid && r_exe_valid && r_exe_mem_read
                        && (r_exe_rd != 5'd0) && (r_state != ST_BUBBLE)
                        && ((w_rs1_used && r_id_inst[19:15] == r_exe_rd)
                         || (w_rs2_used && r_id_inst[24:20] == r_exe_rd));

    assign w_cnt_inc = !FLUSH && (EX_BUSY || w_load_use);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state        <= ST_RUN;
            r_id_inst      <= 32'h0000_0013;
            r_id_valid     <= 1'b0;
            r_exe_valid    <= 1'b0;
            r_exe_imm_sel  <= 4'b0000;
            r_exe_rd       <= 5'd0;
            r_exe_mem_read <= 1'b0;
        end else if (FLUSH) begin
            r_state        <= ST_RUN;
            r_id_valid     <= 1'b0;
            r_exe_valid    <= 1'b0;
            r_exe_rd       <= 5'd0;
            r_exe_mem_read <= 1'b0;
        end else if (EX_BUSY) begin
            r_state        <= ST_HOLD;
        end else if (w_load_use) begin
            r_state        <= ST_BUBBLE;
            r_exe_valid    <= 1'b0;
            r_exe_rd       <= 5'd0;
            r_exe_mem_read <= 1'b0;
        end else begin
            r_state        <= ST_RUN;
            r_exe_valid    <= r_id_valid;
            r_exe_imm_sel  <= w_imm_sel;
            r_exe_rd       <= r_id_valid ? r_id_inst[11:7] : 5'd0;
            r_exe_mem_read <= r_id_valid && (w_opcode == OP_LOAD);
            r_id_inst      <= IF_INST;
            r_id_valid     <= IF_VALID;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_stall_cnt <= '0;
        end else if (w_cnt_inc && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign IMM_SEL      = w_imm_sel;
    assign ID_INST      = r_id_inst;
    assign ID_VALID     = r_id_valid;
    assign STALL_IF     = w_cnt_inc;
    assign EXE_VALID    = r_exe_valid;
    assign EXE_IMM_SEL  = r_exe_imm_sel;
    assign EXE_RD       = r_exe_rd;
    assign EXE_MEM_READ = r_exe_mem_read;
    assign STALL_CNT    = r_stall_cnt;

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed bench for id_issue_ctrl: decode sweep, load-use bubbles, EX_BUSY hold, flush, counter saturation, async reset.
module tb_id_issue_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        IF_VALID;
    logic [31:0] IF_INST;
    logic        EX_BUSY;
    logic        FLUSH;

    logic [3:0]  IMM_SEL,  s_imm_sel;
    logic [31:0] ID_INST,  s_id_inst;
    logic        ID_VALID, s_id_valid;
    logic        STALL_IF, s_stall_if;
    logic        EXE_VALID, s_exe_valid;
    logic [3:0]  EXE_IMM_SEL, s_exe_imm_sel;
    logic [4:0]  EXE_RD, s_exe_rd;
    logic        EXE_MEM_READ, s_exe_mem_read;
    logic [15:0] STALL_CNT;
    logic [1:0]  s_stall_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    id_issue_ctrl #(.CNT_W(16), .LOAD_USE_EN(1'b1)) dut (
        .CLK(CLK), .RESET(RESET), .IF_VALID(IF_VALID), .IF_INST(IF_INST),
        .EX_BUSY(EX_BUSY), .FLUSH(FLUSH), .IMM_SEL(IMM_SEL), .ID_INST(ID_INST),
        .ID_VALID(ID_VALID), .STALL_IF(STALL_IF), .EXE_VALID(EXE_VALID),
        .EXE_IMM_SEL(EXE_IMM_SEL), .EXE_RD(EXE_RD), .EXE_MEM_READ(EXE_MEM_READ),
        .STALL_CNT(STALL_CNT)
    );

    id_issue_ctrl #(.CNT_W(2), .LOAD_USE_EN(1'b1)) dut_small (
        .CLK(CLK), .RESET(RESET), .IF_VALID(IF_VALID), .IF_INST(IF_INST),
        .EX_BUSY(EX_BUSY), .FLUSH(FLUSH), .IMM_SEL(s_imm_sel), .ID_INST(s_id_inst),
        .ID_VALID(s_id_valid), .STALL_IF(s_stall_if), .EXE_VALID(s_exe_valid),
        .EXE_IMM_SEL(s_exe_imm_sel), .EXE_RD(s_exe_rd), .EXE_MEM_READ(s_exe_mem_read),
        .STALL_CNT(s_stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic feed(input logic vld, input logic [31:0] inst);
        IF_VALID = vld;
        IF_INST  = inst;
    endtask

    // Decode sweep vectors: instruction latched with IF_VALID=0, expected IMM_SEL
    logic [31:0] sweep_inst [8] = '{32'h12345037, 32'h0040006F, 32'h00209093, 32'h40205093,
                                    32'h00208463, 32'h0020A223, 32'h002081B3, 32'h0000A103};
    logic [3:0]  sweep_sel  [8] = '{4'b0000, 4'b0001, 4'b0101, 4'b0101,
                                    4'b0011, 4'b0100, 4'b0111, 4'b0010};

    initial begin
        RESET = 1'b1; EX_BUSY = 1'b0; FLUSH = 1'b0;
        feed(1'b0, 32'h0000_0013);
        #3;
        chk("rst_id_inst",   ID_INST,      32'h0000_0013);
        chk("rst_id_valid",  ID_VALID,     0);
        chk("rst_exe_valid", EXE_VALID,    0);
        chk("rst_exe_imm",   EXE_IMM_SEL,  0);
        chk("rst_exe_rd",    EXE_RD,       0);
        chk("rst_exe_mr",    EXE_MEM_READ, 0);
        chk("rst_cnt",       STALL_CNT,    0);
        chk("rst_imm_sel",   IMM_SEL,      4'b0010);
        chk("rst_stall_if",  STALL_IF,     0);
        tick(); tick();
        RESET = 1'b0;

        // Plain issue of addi x1,x0,5
        feed(1'b1, 32'h00500093);
        tick();
        chk("addi_id_valid", ID_VALID, 1);
        chk("addi_imm_sel",  IMM_SEL,  4'b0010);
        feed(1'b0, 32'h0000_0013);
        tick();
        chk("addi_exe_valid", EXE_VALID,    1);
        chk("addi_exe_rd",    EXE_RD,       1);
        chk("addi_exe_mr",    EXE_MEM_READ, 0);
        chk("addi_exe_imm",   EXE_IMM_SEL,  4'b0010);
        chk("addi_cnt",       STALL_CNT,    0);

        for (int i = 0; i < 8; i++) begin
            feed(1'b0, sweep_inst[i]);
            tick();
            chk($sformatf("sweep_imm_%0d", i), IMM_SEL, sweep_sel[i]);
            chk($sformatf("sweep_inst_%0d", i), ID_INST, sweep_inst[i]);
        end
        chk("sweep_id_valid",  ID_VALID,  0);
        chk("sweep_exe_valid", EXE_VALID, 0);
        chk("sweep_exe_rd",    EXE_RD,    0);

        // lw x2 then addi x3,x2,1: one bubble
        feed(1'b1, 32'h0000A103);
        tick();
        feed(1'b1, 32'h00110193);
        #1 chk("lu_pre_stall", STALL_IF, 0);
        tick();
        chk("lu_exe_mr", EXE_MEM_READ, 1);
        chk("lu_exe_rd", EXE_RD, 2);
        chk("lu_stall",  STALL_IF, 1);
        feed(1'b0, 32'h0000_0013);
        tick();
        chk("lu_bubble_valid", EXE_VALID,    0);
        chk("lu_bubble_rd",    EXE_RD,       0);
        chk("lu_bubble_mr",    EXE_MEM_READ, 0);
        chk("lu_held_inst",    ID_INST,      32'h00110193);
        chk("lu_held_valid",   ID_VALID,     1);
        chk("lu_stall_off",    STALL_IF,     0);
        chk("lu_cnt",          STALL_CNT,    1);
        tick();
        chk("lu_issue_valid", EXE_VALID, 1);
        chk("lu_issue_rd",    EXE_RD,    3);
        chk("lu_cnt_after",   STALL_CNT, 1);

        // lw x0 then use of x0: no bubble
        feed(1'b1, 32'h0000A003);
        tick();
        feed(1'b1, 32'h00100193);
        tick();
        chk("lw_x0_mr",    EXE_MEM_READ, 1);
        chk("lw_x0_stall", STALL_IF,     0);

        // lw x2 then lui x2 (rs1 field = 2): no bubble
        feed(1'b1, 32'h0000A103);
        tick();
        feed(1'b1, 32'h00010137);
        tick();
        chk("lui_stall", STALL_IF, 0);
        feed(1'b0, 32'h0000_0013);
        tick();
        chk("lui_issue_valid", EXE_VALID, 1);
        chk("lui_issue_rd",    EXE_RD,    2);
        chk("lui_cnt",         STALL_CNT, 1);

        // lw x2 then add x3,x1,x2: rs2 hazard
        feed(1'b1, 32'h0000A103);
        tick();
        feed(1'b1, 32'h002081B3);
        tick();
        chk("rs2_stall", STALL_IF, 1);
        feed(1'b0, 32'h0000_0013);
        tick();
        chk("rs2_bubble", EXE_VALID, 0);
        chk("rs2_cnt",    STALL_CNT, 2);
        tick();
        chk("rs2_issue_rd", EXE_RD, 3);

        // EX_BUSY for 3 cycles with addi x1 in EX and addi x3 in ID
        feed(1'b1, 32'h00500093);
        tick();
        feed(1'b1, 32'h00110193);
        tick();
        feed(1'b0, 32'h0000_0013);
        EX_BUSY = 1'b1;
        #1 chk("busy_stall_0", STALL_IF, 1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("busy_exe_rd_%0d", i),    EXE_RD,    1);
            chk($sformatf("busy_exe_valid_%0d", i), EXE_VALID, 1);
            chk($sformatf("busy_id_inst_%0d", i),   ID_INST,   32'h00110193);
            chk($sformatf("busy_cnt_%0d", i),       STALL_CNT, 2 + i);
            if (i == 3) EX_BUSY = 1'b0;
            #1 chk($sformatf("busy_stall_%0d", i), STALL_IF, (i < 3) ? 1 : 0);
        end
        chk("small_cnt_sat", s_stall_cnt, 2'd3);
        tick();
        chk("busy_release_rd", EXE_RD,    3);
        chk("busy_release_cnt", STALL_CNT, 5);
        chk("small_cnt_hold",  s_stall_cnt, 2'd3);

        // FLUSH during a load-use stall
        feed(1'b1, 32'h0000A103);
        tick();
        feed(1'b1, 32'h00110193);
        tick();
        chk("fl_stall", STALL_IF, 1);
        FLUSH = 1'b1;
        #1 chk("fl_stall_off", STALL_IF, 0);
        feed(1'b0, 32'h0000_0013);
        tick();
        FLUSH = 1'b0;
        chk("fl_exe_valid", EXE_VALID, 0);
        chk("fl_id_valid",  ID_VALID,  0);
        chk("fl_cnt",       STALL_CNT, 5);

        // RESET pulsed mid-HOLD
        feed(1'b1, 32'h00500093);
        tick();
        feed(1'b0, 32'h0000_0013);
        tick();
        EX_BUSY = 1'b1;
        tick(); tick();
        chk("hold_cnt", STALL_CNT, 7);
        #2 RESET = 1'b1;
        #1;
        chk("arst_exe_valid", EXE_VALID,   0);
        chk("arst_exe_rd",    EXE_RD,      0);
        chk("arst_cnt",       STALL_CNT,   0);
        chk("arst_id_inst",   ID_INST,     32'h0000_0013);
        chk("arst_small_cnt", s_stall_cnt, 2'd0);
        EX_BUSY = 1'b0;
        tick();
        RESET = 1'b0;
        tick();
        chk("post_rst_exe_valid", EXE_VALID, 0);
        chk("post_rst_cnt",       STALL_CNT, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
